// File: rtl/fdiv_arb_pkg.sv
// Shared constants and helpers for the floating-point divider arbiter.
package fdiv_arb_pkg;

    // Bit positions inside the 3-bit divider flag
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_INF  = 1;
    localparam int unsigned FLAG_NAN  = 2;
    localparam int unsigned FLAG_W    = 3;

    // Ceiling log2, returns 0 for n <= 1
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Data width of a float with the given exponent/fraction widths
    function automatic int unsigned calc_w(input int unsigned exp_w, input int unsigned fra_w);
        return exp_w + fra_w + 1;
    endfunction

endpackage

// File: rtl/fdiv_arbiter_if.sv
// Requester, divider and response signals of the divider arbiter.
// slave: arbiter view, master: environment (requesters + divider) view.
interface fdiv_arbiter_if
    import fdiv_arb_pkg::*;
#(
    parameter int unsigned EXP          = 5,
    parameter int unsigned FRA          = 10,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 8
);
    localparam int unsigned W   = calc_w(EXP, FRA);
    localparam int unsigned IDW = clog2(NREQ);
    localparam int unsigned CW  = clog2(MAX_INFLIGHT) + 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      div_a_tdata;
    logic [W-1:0]      div_b_tdata;
    logic              div_a_tvalid;
    logic              div_b_tvalid;
    logic              div_a_tready;
    logic              div_b_tready;
    logic [W-1:0]      div_res_tdata;
    logic              div_res_tvalid;
    logic [FLAG_W-1:0] div_flag;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [FLAG_W-1:0] rsp_flag;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     inflight;
    logic              err_orphan;

    modport slave (
        input  req_valid, req_a, req_b,
        input  div_a_tready, div_b_tready, div_res_tdata, div_res_tvalid, div_flag,
        output req_ready, div_a_tdata, div_b_tdata, div_a_tvalid, div_b_tvalid,
        output rsp_valid, rsp_data, rsp_flag, rsp_id, inflight, err_orphan
    );

    modport master (
        output req_valid, req_a, req_b,
        output div_a_tready, div_b_tready, div_res_tdata, div_res_tvalid, div_flag,
        input  req_ready, div_a_tdata, div_b_tdata, div_a_tvalid, div_b_tvalid,
        input  rsp_valid, rsp_data, rsp_flag, rsp_id, inflight, err_orphan
    );

endinterface

// File: rtl/fdiv_tag_fifo.sv
// In-order FIFO of requester tags, one entry per division in flight.
// Reset is asynchronous and active-high on aresetn.
module fdiv_tag_fifo
    import fdiv_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TW    = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TW-1:0]          din,
    output logic [TW-1:0]          dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [TW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign dout    = mem[rd_ptr];

    // Tag storage, no reset needed since occupancy gates every read
    always_ff @(posedge aclk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fdiv_arbiter.sv
// Shares one floating-point divider between NREQ requesters and routes each
// result back to its owner in issue order.
// Build option: DIV_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
module fdiv_arbiter
    import fdiv_arb_pkg::*;
#(
    parameter int unsigned EXP          = 5,
    parameter int unsigned FRA          = 10,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    fdiv_arbiter_if.slave bus
);
    localparam int unsigned W   = calc_w(EXP, FRA);
    localparam int unsigned IDW = clog2(NREQ);
    localparam int unsigned CW  = clog2(MAX_INFLIGHT) + 1;

    logic [IDW-1:0] grant_id_c;
    logic           grant_any_c;
    logic           issue_ok_c;
    logic           handshake_c;
    logic           pop_c;
    logic [IDW-1:0] tag_head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           issue_vld;

    assign pop_c       = bus.div_res_tvalid & ~fifo_empty;
    assign issue_ok_c  = bus.div_a_tready & bus.div_b_tready & (~fifo_full | pop_c);
    assign handshake_c = grant_any_c & issue_ok_c;

`ifdef DIV_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest valid index wins
    always_comb begin
        logic [IDW-1:0] idx;
        grant_any_c = 1'b0;
        grant_id_c  = '0;
        idx         = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = IDW'(i);
            if (!grant_any_c && bus.req_valid[idx]) begin
                grant_any_c = 1'b1;
                grant_id_c  = idx;
            end
        end
    end
`else
    logic [IDW-1:0] rr;

    // Round-robin: first valid requester at or after rr
    always_comb begin
        logic [IDW-1:0] idx;
        grant_any_c = 1'b0;
        grant_id_c  = '0;
        idx         = '0;
        for (int off = 0; off < int'(NREQ); off++) begin
            idx = IDW'((32'(rr) + 32'(off)) % NREQ);
            if (!grant_any_c && bus.req_valid[idx]) begin
                grant_any_c = 1'b1;
                grant_id_c  = idx;
            end
        end
    end

    // Pointer moves past the winner only when an issue actually happens
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            rr <= '0;
        end else if (handshake_c) begin
            rr <= (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + 1'b1;
        end
    end
`endif

    // Accept goes only to the granted requester, and only if the issue can happen
    always_comb begin
        bus.req_ready = '0;
        if (handshake_c) begin
            bus.req_ready[grant_id_c] = 1'b1;
        end
    end

    // Register the winning operand pair into the divider for one cycle
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            issue_vld       <= 1'b0;
            bus.div_a_tdata <= '0;
            bus.div_b_tdata <= '0;
        end else begin
            issue_vld <= handshake_c;
            if (handshake_c) begin
                bus.div_a_tdata <= bus.req_a[W * 32'(grant_id_c) +: W];
                bus.div_b_tdata <= bus.req_b[W * 32'(grant_id_c) +: W];
            end
        end
    end

    assign bus.div_a_tvalid = issue_vld;
    assign bus.div_b_tvalid = issue_vld;

    // Return results to the owner at the FIFO head; flag results with no owner
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            bus.rsp_valid  <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_data   <= '0;
            bus.rsp_flag   <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (pop_c) begin
                bus.rsp_valid <= NREQ'(1'b1) << tag_head;
                bus.rsp_id    <= tag_head;
                bus.rsp_data  <= bus.div_res_tdata;
                bus.rsp_flag  <= bus.div_flag;
            end
            if (bus.div_res_tvalid && fifo_empty) begin
                bus.err_orphan <= 1'b1;
            end
        end
    end

    assign bus.inflight = fifo_count;

    fdiv_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .TW    (IDW)
    ) u_tag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (handshake_c),
        .pop     (pop_c),
        .din     (grant_id_c),
        .dout    (tag_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter with a fixed-latency divider stand-in.
// The stand-in is only fed divisor 1.0 (0x3C00), so its result is the
// dividend and its flag is the zero flag when the dividend is +/-0.
module tb_fdiv_arbiter;
    import fdiv_arb_pkg::*;

    localparam int unsigned EXP  = 5;
    localparam int unsigned FRA  = 10;
    localparam int unsigned NREQ = 4;
    localparam int unsigned MAXI = 4;
    localparam logic [15:0] ONE  = 16'h3C00;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 aclk = ~aclk;

    fdiv_arbiter_if #(.EXP(EXP), .FRA(FRA), .NREQ(NREQ), .MAX_INFLIGHT(MAXI)) bus ();

    fdiv_arbiter #(.EXP(EXP), .FRA(FRA), .NREQ(NREQ), .MAX_INFLIGHT(MAXI)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    // Divider stand-in: result appears lat_m1+1 cycles after the operand stage
    logic [3:0]  lat_m1 = 4'd1;
    logic        orphan_pulse = 1'b0;
    logic        pipe_v [16];
    logic [15:0] pipe_d [16];
    logic [2:0]  pipe_f [16];

    initial begin
        for (int k = 0; k < 16; k++) begin
            pipe_v[k] = 1'b0;
            pipe_d[k] = '0;
            pipe_f[k] = '0;
        end
    end

    always @(posedge aclk) begin
        pipe_v[0] <= bus.div_a_tvalid;
        pipe_d[0] <= bus.div_a_tdata;
        pipe_f[0] <= (bus.div_a_tdata[14:0] == 15'd0) ? 3'(1 << FLAG_ZERO) : 3'b000;
        for (int k = 1; k < 16; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
            pipe_f[k] <= pipe_f[k-1];
        end
    end

    assign bus.div_res_tvalid = pipe_v[lat_m1] | orphan_pulse;
    assign bus.div_res_tdata  = pipe_d[lat_m1];
    assign bus.div_flag       = pipe_f[lat_m1];

    // Response log: {flag[3], valid[4], id[2], data[16]}
    logic [31:0] mon_q [$];

    always @(negedge aclk) begin
        if (bus.rsp_valid != '0) begin
            mon_q.push_back({7'd0, bus.rsp_flag, bus.rsp_valid, bus.rsp_id, bus.rsp_data});
        end
    end

    function automatic logic [31:0] rec(input int k);
        return (k < mon_q.size()) ? mon_q[k] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [15:0] a_val(input int i);
        return 16'h4000 + 16'(i * 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = ONE;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int k;
        k = 0;
        while (mon_q.size() < n && k < 60) begin
            cyc();
            k++;
        end
        check(tag, 32'(mon_q.size()), 32'(n));
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (bus.inflight != '0 && k < 60) begin
            cyc();
            k++;
        end
        repeat (18) cyc();
        check(tag, 32'(bus.inflight), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        logic       exp_rdy;
        int         k;

        aresetn          = 1'b1;
        bus.req_valid    = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.div_a_tready = 1'b1;
        bus.div_b_tready = 1'b1;
        do_reset();

        // Reset state
        check("rst_req_ready",  32'(bus.req_ready),    32'd0);
        check("rst_div_tvalid", 32'(bus.div_a_tvalid), 32'd0);
        check("rst_rsp_valid",  32'(bus.rsp_valid),    32'd0);
        check("rst_inflight",   32'(bus.inflight),     32'd0);
        check("rst_err_orphan", 32'(bus.err_orphan),   32'd0);

        // Single request from requester 2: 2.0 / 1.0
        mon_q.delete();
        cyc();
        set_req(2, 16'h4000);
        bus.req_valid = 4'b0100;
        #1;
        check("t1_req_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = '0;
        #1;
        check("t1_req_ready_off", 32'(bus.req_ready),    32'd0);
        check("t1_div_a_tvalid",  32'(bus.div_a_tvalid), 32'd1);
        check("t1_div_b_tvalid",  32'(bus.div_b_tvalid), 32'd1);
        check("t1_div_a_tdata",   32'(bus.div_a_tdata),  32'h4000);
        check("t1_div_b_tdata",   32'(bus.div_b_tdata),  32'h3C00);
        check("t1_inflight",      32'(bus.inflight),     32'd1);
        cyc();
        check("t1_tvalid_once",   32'(bus.div_a_tvalid), 32'd0);
        wait_rsp(1, "t1_rsp_count");
        check("t1_rsp_valid", 32'(rec(0)[21:18]), 32'h4);
        check("t1_rsp_id",    32'(rec(0)[17:16]), 32'd2);
        check("t1_rsp_data",  32'(rec(0)[15:0]),  32'h4000);
        check("t1_rsp_flag",  32'(rec(0)[24:22]), 32'd0);
        cyc();
        check("t1_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        check("t1_inflight0", 32'(bus.inflight),  32'd0);

        // Zero dividend from requester 0 returns the zero flag
        set_req(0, 16'h0000);
        bus.req_valid = 4'b0001;
        #1;
        check("t1b_req_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = '0;
        wait_rsp(2, "t1b_rsp_count");
        check("t1b_rsp_valid", 32'(rec(1)[21:18]), 32'h1);
        check("t1b_rsp_id",    32'(rec(1)[17:16]), 32'd0);
        check("t1b_rsp_data",  32'(rec(1)[15:0]),  32'h0000);
        check("t1b_rsp_flag",  32'(rec(1)[24:22]), 32'(1 << FLAG_ZERO));

        // All four valid for 8 cycles
        drain("t1_drain");
        do_reset();
        mon_q.delete();
        for (int i = 0; i < 4; i++) set_req(i, a_val(i));
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
`ifdef DIV_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'(1 << (c % 4));
`endif
            check("t2_grant", 32'(bus.req_ready), 32'(exp_g));
            cyc();
        end
        bus.req_valid = '0;
        wait_rsp(8, "t2_rsp_count");
        for (int c = 0; c < 8; c++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
            k = 0;
`else
            k = c % 4;
`endif
            check("t2_rsp_id",    32'(rec(c)[17:16]), 32'(k));
            check("t2_rsp_valid", 32'(rec(c)[21:18]), 32'(1 << k));
            check("t2_rsp_data",  32'(rec(c)[15:0]),  32'(a_val(k)));
        end

        // Saturation: depth 4, divider latency 6
        drain("t2_drain");
        lat_m1 = 4'd5;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 14; c++) begin
            #1;
            exp_rdy = (c < 4) || (c >= 7 && c < 11);
            check("t3_ready", 32'(|bus.req_ready), 32'(exp_rdy));
            check("t3_inflight_le_max", 32'(bus.inflight <= 3'(MAXI)), 32'd1);
            cyc();
        end
        bus.req_valid = '0;
        drain("t3_drain");
        lat_m1 = 4'd1;

        // Divider not ready: rr must hold
        do_reset();
        set_req(1, a_val(1));
        bus.req_valid = 4'b0010;
        #1;
        check("t4_first_grant", 32'(bus.req_ready), 32'h2);
        cyc();
        bus.req_valid = '0;
        drain("t4_drain0");
        bus.div_a_tready = 1'b0;
        bus.req_valid    = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_no_ready",    32'(bus.req_ready),    32'd0);
            check("t4_no_push",     32'(bus.inflight),     32'd0);
            check("t4_no_issue",    32'(bus.div_a_tvalid), 32'd0);
            cyc();
        end
        bus.div_a_tready = 1'b1;
        #1;
`ifdef DIV_ARB_FIXED_PRIO_EN
        check("t4_resume_grant", 32'(bus.req_ready), 32'h1);
`else
        check("t4_resume_grant", 32'(bus.req_ready), 32'h4);
`endif
        cyc();
        bus.req_valid = '0;
        check("t4_resume_push", 32'(bus.inflight), 32'd1);
        drain("t4_drain1");

        // Orphan result with the FIFO empty
        mon_q.delete();
        orphan_pulse = 1'b1;
        cyc();
        orphan_pulse = 1'b0;
        check("t5_err_set",     32'(bus.err_orphan), 32'd1);
        check("t5_no_rsp",      32'(bus.rsp_valid),  32'd0);
        check("t5_inflight",    32'(bus.inflight),   32'd0);
        repeat (3) cyc();
        check("t5_err_sticky",  32'(bus.err_orphan), 32'd1);
        check("t5_no_rsp_log",  32'(mon_q.size()),   32'd0);
        do_reset();
        check("t5_err_cleared", 32'(bus.err_orphan), 32'd0);

        // Reset mid-flight with three divisions outstanding
        lat_m1 = 4'd5;
        mon_q.delete();
        for (int i = 0; i < 4; i++) set_req(i, a_val(i));
        bus.req_valid = 4'b0111;
        repeat (3) cyc();
        bus.req_valid = '0;
        check("t6_inflight3", 32'(bus.inflight), 32'd3);
        aresetn = 1'b1;
        #1;
        check("t6_rst_req_ready",  32'(bus.req_ready),    32'd0);
        check("t6_rst_tvalid",     32'(bus.div_a_tvalid), 32'd0);
        check("t6_rst_a_tdata",    32'(bus.div_a_tdata),  32'd0);
        check("t6_rst_b_tdata",    32'(bus.div_b_tdata),  32'd0);
        check("t6_rst_rsp_valid",  32'(bus.rsp_valid),    32'd0);
        check("t6_rst_rsp_id",     32'(bus.rsp_id),       32'd0);
        check("t6_rst_rsp_data",   32'(bus.rsp_data),     32'd0);
        check("t6_rst_rsp_flag",   32'(bus.rsp_flag),     32'd0);
        check("t6_rst_inflight",   32'(bus.inflight),     32'd0);
        check("t6_rst_err_orphan", 32'(bus.err_orphan),   32'd0);
        cyc();
        aresetn = 1'b0;
        k = 0;
        while (!bus.err_orphan && k < 20) begin
            cyc();
            k++;
        end
        check("t6_late_orphan", 32'(bus.err_orphan), 32'd1);
        check("t6_no_rsp_log",  32'(mon_q.size()),   32'd0);
        repeat (18) cyc();
        lat_m1 = 4'd1;
        do_reset();
        check("t6_err_cleared", 32'(bus.err_orphan), 32'd0);

        // Requesters 1 and 3 both valid
        set_req(1, a_val(1));
        set_req(3, a_val(3));
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            #1;
`ifdef DIV_ARB_FIXED_PRIO_EN
            exp_g = 4'b0010;
`else
            exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            check("t7_grant", 32'(bus.req_ready), 32'(exp_g));
            cyc();
        end
        bus.req_valid = '0;
        drain("t7_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
